multi_square_attacked: RTL

Sequential attack checker for the move generator and legality stages. It takes a board snapshot plus a run-time list of target squares and reports, per square, whether the selected side attacks it. The target squares and attacking side are inputs, not elaboration parameters. One target square is evaluated per cycle, which lets a single instance serve castling-path checks (three squares) and king-safety checks (one square) without one hard-wired instance per square.

---
 rtl/multi_square_attacked.sv | 188 ++++++++++++++++++
 1 files changed

// File: rtl/multi_square_attacked.sv
// Sequential attack checker: scans a run-time list of target squares, one per cycle,
// against a captured board snapshot and reports which ones the selected side attacks.
`ifndef EMPTY_POSN
`define EMPTY_POSN   4'd0
`endif
`ifndef WHITE_PAWN
`define WHITE_PAWN   4'd1
`define WHITE_KNIGHT 4'd2
`define WHITE_BISHOP 4'd3
`define WHITE_ROOK   4'd4
`define WHITE_QUEEN  4'd5
`define WHITE_KING   4'd6
`endif
`ifndef BLACK_PAWN
`define BLACK_PAWN   4'd9
`define BLACK_KNIGHT 4'd10
`define BLACK_BISHOP 4'd11
`define BLACK_ROOK   4'd12
`define BLACK_QUEEN  4'd13
`define BLACK_KING   4'd14
`endif
`ifndef WHITE_ATTACK
`define WHITE_ATTACK 1'b1
`endif

module multi_square_attacked #(
    parameter int PIECE_WIDTH = 4,
    parameter int BOARD_WIDTH = 256,
    parameter int SQUARES     = 3,
    parameter bit EARLY_EXIT  = 1'b0
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [BOARD_WIDTH-1:0] board,
    input  logic                   board_valid,
    input  logic [SQUARES*6-1:0]   squares,
    input  logic                   attacker,
    output logic                   busy,
    output logic [SQUARES-1:0]     attacked_mask,
    output logic                   attacked_any,
    output logic                   attacked_valid
);
    localparam int IDX_W = $clog2(SQUARES + 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(SQUARES - 1);

    typedef logic [PIECE_WIDTH-1:0] piece_t;
    typedef enum logic {IDLE, SCAN} state_t;

    localparam piece_t EMPTY = piece_t'(`EMPTY_POSN);

    state_t state, state_next;
    logic   start, finish;

    logic [IDX_W-1:0]       idx;
    logic [BOARD_WIDTH-1:0] board_p0;
    logic [SQUARES*6-1:0]   squares_p0;
    logic                   attacker_p0;
    logic [SQUARES-1:0]     mask;

    logic [5:0]             target;
    logic                   hit;
    logic                   done;
    logic [SQUARES-1:0]     mask_upd;

    // Offsets live in 4-bit signed space: any sum outside 0..7 lands negative,
    // so "on board" is simply "both sign bits clear" and files never wrap.
    function automatic logic on_board(input logic signed [3:0] r, input logic signed [3:0] c);
        return !r[3] && !c[3];
    endfunction

    function automatic piece_t piece_at(input logic [BOARD_WIDTH-1:0] b, input logic [5:0] s);
        return b[32'(s)*PIECE_WIDTH +: PIECE_WIDTH];
    endfunction

    function automatic logic square_attacked(input logic [BOARD_WIDTH-1:0] b,
                                             input logic [5:0] sq, input logic white);
        logic signed [3:0] r, c, rr, cc, pawn_dr;
        piece_t pawn, knight, bishop, rook, queen, king, pc;
        logic hit_f, stop;
        r       = {1'b0, sq[5:3]};
        c       = {1'b0, sq[2:0]};
        pawn    = white ? piece_t'(`WHITE_PAWN)   : piece_t'(`BLACK_PAWN);
        knight  = white ? piece_t'(`WHITE_KNIGHT) : piece_t'(`BLACK_KNIGHT);
        bishop  = white ? piece_t'(`WHITE_BISHOP) : piece_t'(`BLACK_BISHOP);
        rook    = white ? piece_t'(`WHITE_ROOK)   : piece_t'(`BLACK_ROOK);
        queen   = white ? piece_t'(`WHITE_QUEEN)  : piece_t'(`BLACK_QUEEN);
        king    = white ? piece_t'(`WHITE_KING)   : piece_t'(`BLACK_KING);
        pawn_dr = white ? -4'sd1 : 4'sd1;
        hit_f   = 1'b0;
        for (int dr = -2; dr <= 2; dr++) begin
            for (int dc = -2; dc <= 2; dc++) begin
                rr = r + 4'(dr);
                cc = c + 4'(dc);
                if (on_board(rr, cc)) begin
                    pc = piece_at(b, {rr[2:0], cc[2:0]});
                    if ((dr*dr + dc*dc == 5) && pc == knight) hit_f = 1'b1;
                    if ((dr*dr <= 1) && (dc*dc <= 1) && (dr != 0 || dc != 0) && pc == king)
                        hit_f = 1'b1;
                    if ((4'(dr) == pawn_dr) && (dc == 1 || dc == -1) && pc == pawn) hit_f = 1'b1;
                end
            end
        end
        for (int dr = -1; dr <= 1; dr++) begin
            for (int dc = -1; dc <= 1; dc++) begin
                if (dr != 0 || dc != 0) begin
                    stop = 1'b0;
                    for (int d = 1; d <= 7; d++) begin
                        rr = r + 4'(dr * d);
                        cc = c + 4'(dc * d);
                        if (!stop) begin
                            if (!on_board(rr, cc)) begin
                                stop = 1'b1;
                            end else begin
                                pc = piece_at(b, {rr[2:0], cc[2:0]});
                                if (pc != EMPTY) begin
                                    stop = 1'b1;
                                    if (pc == queen || pc == ((dr == 0 || dc == 0) ? rook : bishop))
                                        hit_f = 1'b1;
                                end
                            end
                        end
                    end
                end
            end
        end
        return hit_f;
    endfunction

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (board_valid) state_next = SCAN;
            SCAN:    if (done)        state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        busy   = (state == SCAN);
        start  = (state == IDLE) && board_valid;
        finish = (state == SCAN) && done;
    end

    // Evaluation stage: captured snapshot -> result for target idx
    always_comb begin
        target        = squares_p0[idx*6 +: 6];
        hit           = square_attacked(board_p0, target, attacker_p0 == `WHITE_ATTACK);
        done          = (idx == LAST_IDX) || (EARLY_EXIT && hit);
        mask_upd      = mask;
        mask_upd[idx] = hit;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            idx            <= '0;
            attacked_valid <= 1'b0;
            attacked_mask  <= '0;
            attacked_any   <= 1'b0;
        end else begin
            attacked_valid <= finish;
            if (start)
                idx <= '0;
            else if (busy && !done)
                idx <= idx + IDX_W'(1);
            if (finish) begin
                attacked_mask <= mask_upd;
                attacked_any  <= |mask_upd;
            end
        end
    end

    // Capture stage: query snapshot and running mask
    always_ff @(posedge clk) begin
        if (start) begin
            board_p0    <= board;
            squares_p0  <= squares;
            attacker_p0 <= attacker;
            mask        <= '0;
        end else if (busy) begin
            mask <= mask_upd;
        end
    end
endmodule
